cp0_regfile: RTL and testbench
==============================

CP0_REGFILE -- requirements
Module: cp0_regfile

Interface
REQ-001 Parameter EBASE_RST, default 32'h8000_0000, reset value of EBase.
REQ-002 Parameter PRID, default 32'h0001_8000, constant PRId read value.
REQ-003 One clock; reset is asynchronous and active-low; ports clk, resetn.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 resetn  in  1  asynchronous active-low reset.
REQ-006 we / waddr / wsel / wdata  in  1/5/3/32  MTC0 write strobe, register number, select, data.
REQ-007 raddr / rsel  in  5/3  MFC0 read address; rdata  out  32  read data.
REQ-008 exc_we  in  1  exception commit pulse from the exception unit.
REQ-009 exc_code  in  5  ExcCode to record; exc_epc  in  32  victim PC; exc_bd  in  1  victim in delay slot.
REQ-010 badvaddr_we / badvaddr_in  in  1/32  BadVAddr update strobe and value.
REQ-011 clear_exl  in  1  ERET commit pulse.
REQ-012 hw_int  in  6  level-sensitive external interrupt lines.
REQ-013 epc_out  out  32  current EPC; ebase_out  out  32  current EBase.
REQ-014 sr_exl / sr_bev / cause_iv  out  1 each  Status.EXL, Status.BEV, Cause.IV.
REQ-015 allow_int  out  1  Status.IE & !Status.EXL.
REQ-016 interrupt_flag  out  8  Cause.IP[7:0] & Status.IM[7:0].
REQ-017 timer_int  out  1  Cause.TI.

Function
REQ-018 Registers (num,sel): BadVAddr(8,0), Count(9,0), Compare(11,0), Status(12,0), Cause(13,0), EPC(14,0), PRId(15,0), EBase(15,1); rdata SHALL be 0 for any other address.
REQ-019 rdata SHALL be combinational from current register state; read-during-write returns the old value.
REQ-020 Status writable bits: BEV[22], IM[15:8], EXL[1], IE[0]; all others read 0.
REQ-021 Cause: BD[31], TI[30], IV[23], IP[15:8], ExcCode[6:2]; MTC0 writes only IV and IP[1:0].
REQ-022 Cause.IP[7:2] SHALL register every cycle as {hw_int[5] | TI, hw_int[4:0]} (one-cycle latency to interrupt_flag).
REQ-023 EBase read = {2'b10, ebase[29:12], 12'h000}; MTC0 writes bits[29:12] only.
REQ-024 BadVAddr written only by badvaddr_we; MTC0 to it ignored.
REQ-025 Count SHALL increment by 1 every second clock (internal phase toggle), wrapping 32'hFFFF_FFFF -> 0.
REQ-026 MTC0 Count loads wdata and suppresses that cycle's increment; phase toggle unaffected.
REQ-027 TI SHALL set the cycle after Count == Compare; MTC0 Compare clears TI, winning over a same-cycle set.
REQ-028 exc_we: ExcCode <= exc_code, EXL <= 1; if EXL was 0: EPC <= exc_epc, BD <= exc_bd; if EXL was 1, EPC and BD hold.
REQ-029 clear_exl (without exc_we): EXL <= 0.
REQ-030 Priority per field: exc_we > clear_exl > MTC0; same-cycle badvaddr_we and MTC0 to other registers both take effect.
REQ-031 All outputs except rdata SHALL be registered state or direct logic of registered state.

Reset
REQ-032 On resetn low, asynchronously: Status = 32'h0040_0000 (BEV=1), Cause = 0, EPC = 0, BadVAddr = 0, Count = 0, Compare = 0, TI = 0, phase = 0, EBase = EBASE_RST.
REQ-033 During reset, outputs: sr_bev=1, sr_exl=0, allow_int=0, interrupt_flag=0, timer_int=0, epc_out=0, ebase_out=EBASE_RST.
REQ-034 Reset asserted mid-operation (e.g. coincident with exc_we) SHALL override all updates.

Verification
REQ-035 Reset release, read (12,0) -> 32'h0040_0000; (15,1) -> 32'h8000_0000; (15,0) -> PRID.
REQ-036 Status=32'h0000_0401, hw_int=6'b000001 -> interrupt_flag=8'h04 and allow_int=1 one cycle later.
REQ-037 exc_we, exc_code=5'h08, exc_epc=32'hBFC0_0100, exc_bd=1 with EXL=0 -> EPC=32'hBFC0_0100, Cause[31]=1, Cause[6:2]=8, EXL=1; second exc_we with exc_epc=32'h1234 -> EPC unchanged, ExcCode updated.
REQ-038 exc_we and clear_exl same cycle -> EXL=1; next clear_exl alone -> EXL=0, allow_int follows IE.
REQ-039 Compare=10, Count=8 -> TI=1 after Count reaches 10 (+1 cycle), Cause[15]=1; MTC0 Compare -> TI=0 next cycle.
REQ-040 MTC0 Count=32'hFFFF_FFFF -> Count reads 0 two cycles later; MTC0 to (3,0) -> read returns 0, no state change.

Source files
------------

// File: rtl/cp0_regfile.sv
// MIPS-style CP0 register file: MFC0/MTC0 access, exception/ERET bookkeeping,
// free-running Count/Compare timer and interrupt pending/mask outputs.
module cp0_regfile #(
  parameter logic [31:0] EBASE_RST = 32'h8000_0000,
  parameter logic [31:0] PRID      = 32'h0001_8000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [2:0]  wsel,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  input  logic [2:0]  rsel,
  output logic [31:0] rdata,
  input  logic        exc_we,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_epc,
  input  logic        exc_bd,
  input  logic        badvaddr_we,
  input  logic [31:0] badvaddr_in,
  input  logic        clear_exl,
  input  logic [5:0]  hw_int,
  output logic [31:0] epc_out,
  output logic [31:0] ebase_out,
  output logic        sr_exl,
  output logic        sr_bev,
  output logic        cause_iv,
  output logic        allow_int,
  output logic [7:0]  interrupt_flag,
  output logic        timer_int
);

  // {register number, select} codes of the implemented registers
  typedef enum logic [7:0] {
    REG_BADVADDR = 8'h40,
    REG_COUNT    = 8'h48,
    REG_COMPARE  = 8'h58,
    REG_STATUS   = 8'h60,
    REG_CAUSE    = 8'h68,
    REG_EPC      = 8'h70,
    REG_PRID     = 8'h78,
    REG_EBASE    = 8'h79
  } cp0_reg_e;

  logic        st_bev;
  logic [7:0]  st_im;
  logic        st_exl;
  logic        st_ie;

  logic        ca_bd;
  logic        ca_ti;
  logic        ca_iv;
  logic [5:0]  ca_ip_hw;
  logic [1:0]  ca_ip_sw;
  logic [4:0]  ca_exc_code;

  logic [31:0] epc_r;
  logic [31:0] badvaddr_r;
  logic [31:0] count_r;
  logic [31:0] compare_r;
  logic        phase_r;
  logic [17:0] ebase_r;

  logic [7:0]  wreg;
  logic [7:0]  rreg;
  logic        wr_status;
  logic        wr_cause;
  logic        wr_epc;
  logic        wr_count;
  logic        wr_compare;
  logic        wr_ebase;

  logic [31:0] status_word;
  logic [31:0] cause_word;
  logic [31:0] ebase_word;

  assign wreg = {waddr, wsel};
  assign rreg = {raddr, rsel};

  always_comb begin
    wr_status  = 1'b0;
    wr_cause   = 1'b0;
    wr_epc     = 1'b0;
    wr_count   = 1'b0;
    wr_compare = 1'b0;
    wr_ebase   = 1'b0;
    if (we) begin
      case (wreg)
        REG_STATUS:  wr_status  = 1'b1;
        REG_CAUSE:   wr_cause   = 1'b1;
        REG_EPC:     wr_epc     = 1'b1;
        REG_COUNT:   wr_count   = 1'b1;
        REG_COMPARE: wr_compare = 1'b1;
        REG_EBASE:   wr_ebase   = 1'b1;
        default: ;
      endcase
    end
  end

  // Status: EXL ownership is exception commit, then ERET, then MTC0
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_bev <= 1'b1;
      st_im  <= '0;
      st_exl <= 1'b0;
      st_ie  <= 1'b0;
    end else begin
      if (wr_status) begin
        st_bev <= wdata[22];
        st_im  <= wdata[15:8];
        st_ie  <= wdata[0];
      end
      if (exc_we)
        st_exl <= 1'b1;
      else if (clear_exl)
        st_exl <= 1'b0;
      else if (wr_status)
        st_exl <= wdata[1];
    end
  end

  // Cause, EPC and BadVAddr; a nested exception (EXL already set) keeps EPC/BD
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ca_bd       <= 1'b0;
      ca_iv       <= 1'b0;
      ca_ip_hw    <= '0;
      ca_ip_sw    <= '0;
      ca_exc_code <= '0;
      epc_r       <= '0;
      badvaddr_r  <= '0;
    end else begin
      ca_ip_hw <= {hw_int[5] | ca_ti, hw_int[4:0]};
      if (wr_cause) begin
        ca_iv    <= wdata[23];
        ca_ip_sw <= wdata[9:8];
      end
      if (exc_we) begin
        ca_exc_code <= exc_code;
        if (!st_exl) begin
          epc_r <= exc_epc;
          ca_bd <= exc_bd;
        end
      end else if (wr_epc) begin
        epc_r <= wdata;
      end
      if (badvaddr_we)
        badvaddr_r <= badvaddr_in;
    end
  end

  // Timer: Count advances on odd phases; an MTC0 Count replaces that cycle's step
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_r   <= '0;
      compare_r <= '0;
      phase_r   <= 1'b0;
      ca_ti     <= 1'b0;
    end else begin
      phase_r <= ~phase_r;
      if (wr_count)
        count_r <= wdata;
      else if (phase_r)
        count_r <= count_r + 32'd1;
      if (wr_compare)
        compare_r <= wdata;
      if (wr_compare)
        ca_ti <= 1'b0;
      else if (count_r == compare_r)
        ca_ti <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      ebase_r <= EBASE_RST[29:12];
    else if (wr_ebase)
      ebase_r <= wdata[29:12];
  end

  assign status_word = {9'b0, st_bev, 6'b0, st_im, 6'b0, st_exl, st_ie};
  assign cause_word  = {ca_bd, ca_ti, 6'b0, ca_iv, 7'b0, ca_ip_hw, ca_ip_sw,
                        1'b0, ca_exc_code, 2'b0};
  assign ebase_word  = {2'b10, ebase_r, 12'h000};

  always_comb begin
    rdata = '0;
    case (rreg)
      REG_BADVADDR: rdata = badvaddr_r;
      REG_COUNT:    rdata = count_r;
      REG_COMPARE:  rdata = compare_r;
      REG_STATUS:   rdata = status_word;
      REG_CAUSE:    rdata = cause_word;
      REG_EPC:      rdata = epc_r;
      REG_PRID:     rdata = PRID;
      REG_EBASE:    rdata = ebase_word;
      default:      rdata = '0;
    endcase
  end

  assign epc_out        = epc_r;
  assign ebase_out      = ebase_word;
  assign sr_exl         = st_exl;
  assign sr_bev         = st_bev;
  assign cause_iv       = ca_iv;
  assign allow_int      = st_ie & ~st_exl;
  assign interrupt_flag = {ca_ip_hw, ca_ip_sw} & st_im;
  assign timer_int      = ca_ti;

endmodule

// File: tb/tb_cp0_regfile.sv
// Randomized bench for cp0_regfile against a word-level register model.
module tb_cp0_regfile;
  localparam logic [31:0] EBASE_RST = 32'h8000_0000;
  localparam logic [31:0] PRID      = 32'h0001_8000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        we;
  logic [4:0]  waddr;
  logic [2:0]  wsel;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [2:0]  rsel;
  logic [31:0] rdata;
  logic        exc_we;
  logic [4:0]  exc_code;
  logic [31:0] exc_epc;
  logic        exc_bd;
  logic        badvaddr_we;
  logic [31:0] badvaddr_in;
  logic        clear_exl;
  logic [5:0]  hw_int;
  logic [31:0] epc_out;
  logic [31:0] ebase_out;
  logic        sr_exl;
  logic        sr_bev;
  logic        cause_iv;
  logic        allow_int;
  logic [7:0]  interrupt_flag;
  logic        timer_int;

  cp0_regfile #(.EBASE_RST(EBASE_RST), .PRID(PRID)) dut (
    .clk(clk), .resetn(resetn),
    .we(we), .waddr(waddr), .wsel(wsel), .wdata(wdata),
    .raddr(raddr), .rsel(rsel), .rdata(rdata),
    .exc_we(exc_we), .exc_code(exc_code), .exc_epc(exc_epc), .exc_bd(exc_bd),
    .badvaddr_we(badvaddr_we), .badvaddr_in(badvaddr_in),
    .clear_exl(clear_exl), .hw_int(hw_int),
    .epc_out(epc_out), .ebase_out(ebase_out),
    .sr_exl(sr_exl), .sr_bev(sr_bev), .cause_iv(cause_iv),
    .allow_int(allow_int), .interrupt_flag(interrupt_flag), .timer_int(timer_int)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural model: whole 32-bit register images, updated from the rules
  logic [31:0] m_status, m_cause, m_epc, m_bad, m_count, m_compare, m_ebase;
  logic        m_phase;
  logic [31:0] n_status, n_cause, n_epc, n_bad, n_count, n_compare, n_ebase;
  logic        n_phase;

  function automatic bit is_reg(input int num, input int sel);
    return (int'(waddr) == num) && (int'(wsel) == sel);
  endfunction

  task automatic model_reset();
    m_status = 32'h0040_0000; m_cause = 0; m_epc = 0; m_bad = 0;
    m_count = 0; m_compare = 0; m_ebase = EBASE_RST; m_phase = 1'b0;
  endtask

  function automatic logic [31:0] m_read(input int num, input int sel);
    if (sel == 0 && num == 8)  return m_bad;
    if (sel == 0 && num == 9)  return m_count;
    if (sel == 0 && num == 11) return m_compare;
    if (sel == 0 && num == 12) return m_status;
    if (sel == 0 && num == 13) return m_cause;
    if (sel == 0 && num == 14) return m_epc;
    if (sel == 0 && num == 15) return PRID;
    if (sel == 1 && num == 15) return m_ebase;
    return 32'h0;
  endfunction

  task automatic model_next();
    n_status = m_status; n_cause = m_cause; n_epc = m_epc; n_bad = m_bad;
    n_count = m_count; n_compare = m_compare; n_ebase = m_ebase;
    n_phase = !m_phase;
    if (we && is_reg(12, 0)) n_status = wdata & 32'h0040_FF03;
    if (we && is_reg(13, 0)) n_cause = (m_cause & ~32'h0080_0300) | (wdata & 32'h0080_0300);
    if (we && is_reg(14, 0)) n_epc = wdata;
    if (we && is_reg(11, 0)) n_compare = wdata;
    if (we && is_reg(15, 1)) n_ebase = (m_ebase & ~32'h3FFF_F000) | (wdata & 32'h3FFF_F000);
    if (we && is_reg(9, 0)) n_count = wdata;
    else if (m_phase) n_count = m_count + 1;
    if (m_count == m_compare) n_cause[30] = 1'b1;
    if (we && is_reg(11, 0)) n_cause[30] = 1'b0;
    n_cause[15:10] = {hw_int[5] | m_cause[30], hw_int[4:0]};
    if (clear_exl) n_status[1] = 1'b0;
    if (exc_we) begin
      n_cause[6:2] = exc_code;
      n_status[1] = 1'b1;
      if (!m_status[1]) begin
        n_epc = exc_epc;
        n_cause[31] = exc_bd;
      end else begin
        n_epc = m_epc;
      end
    end
    if (badvaddr_we) n_bad = badvaddr_in;
  endtask

  task automatic rd(input int num, input int sel, output logic [31:0] d);
    raddr = 5'(num); rsel = 3'(sel);
    #1;
    d = rdata;
  endtask

  task automatic check_outputs();
    int num, sel;
    logic [31:0] d;
    check("epc_out", epc_out, m_epc);
    check("ebase_out", ebase_out, m_ebase);
    check("sr_exl", sr_exl, m_status[1]);
    check("sr_bev", sr_bev, m_status[22]);
    check("cause_iv", cause_iv, m_cause[23]);
    check("allow_int", allow_int, m_status[0] & ~m_status[1]);
    check("interrupt_flag", interrupt_flag, m_cause[15:8] & m_status[15:8]);
    check("timer_int", timer_int, m_cause[30]);
    num = $urandom_range(0, 31);
    if ($urandom_range(0, 3) != 0) num = 8 + $urandom_range(0, 7);
    sel = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : ((num == 15) ? $urandom_range(0, 1) : 0);
    rd(num, sel, d);
    check($sformatf("rdata(%0d,%0d)", num, sel), d, m_read(num, sel));
  endtask

  // Inputs are stable here; one clock edge, then outputs are checked on the falling edge
  task automatic cycle();
    model_next();
    @(posedge clk);
    m_status = n_status; m_cause = n_cause; m_epc = n_epc; m_bad = n_bad;
    m_count = n_count; m_compare = n_compare; m_ebase = n_ebase; m_phase = n_phase;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    we = 0; exc_we = 0; clear_exl = 0; badvaddr_we = 0;
  endtask

  task automatic mtc0(input int num, input int sel, input logic [31:0] d);
    we = 1; waddr = 5'(num); wsel = 3'(sel); wdata = d;
    cycle();
    we = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 0;
    #1;
    check("rst_sr_bev", sr_bev, 1);
    check("rst_sr_exl", sr_exl, 0);
    check("rst_allow_int", allow_int, 0);
    check("rst_interrupt_flag", interrupt_flag, 0);
    check("rst_timer_int", timer_int, 0);
    check("rst_epc_out", epc_out, 0);
    check("rst_ebase_out", ebase_out, EBASE_RST);
    model_reset();
    repeat (2) @(negedge clk);
    resetn = 1;
  endtask

  initial begin
    logic [31:0] d;
    bit seen;
    resetn = 1; idle();
    waddr = 0; wsel = 0; wdata = 0; raddr = 0; rsel = 0;
    exc_code = 0; exc_epc = 0; exc_bd = 0; badvaddr_in = 0; hw_int = 0;
    model_reset();
    #2 resetn = 0;
    do_reset();

    rd(12, 0, d); check("rst_status", d, 32'h0040_0000);
    rd(15, 1, d); check("rst_ebase", d, 32'h8000_0000);
    rd(15, 0, d); check("prid", d, PRID);

    // Interrupt pending/mask path
    hw_int = 6'b000001;
    mtc0(12, 0, 32'h0000_0401);
    check("int_flag_ip2", interrupt_flag, 8'h04);
    check("allow_int_ie", allow_int, 1);

    // Exception entry, then a nested one that must not overwrite EPC/BD
    exc_we = 1; exc_code = 5'h08; exc_epc = 32'hBFC0_0100; exc_bd = 1;
    cycle();
    exc_we = 0;
    check("exc_epc", epc_out, 32'hBFC0_0100);
    check("exc_exl", sr_exl, 1);
    rd(13, 0, d);
    check("exc_bd", d[31], 1);
    check("exc_code", d[6:2], 5'h08);
    exc_we = 1; exc_code = 5'h0C; exc_epc = 32'h0000_1234; exc_bd = 0;
    cycle();
    exc_we = 0;
    check("nested_epc", epc_out, 32'hBFC0_0100);
    rd(13, 0, d);
    check("nested_code", d[6:2], 5'h0C);
    check("nested_bd", d[31], 1);

    exc_we = 1; clear_exl = 1;
    cycle();
    exc_we = 0;
    check("exc_beats_eret", sr_exl, 1);
    cycle();
    clear_exl = 0;
    check("eret_exl", sr_exl, 0);
    check("eret_allow_int", allow_int, 1);

    // Count/Compare timer
    mtc0(11, 0, 32'd10);
    mtc0(9, 0, 32'd8);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle();
      seen = timer_int;
    end
    check("ti_set", seen, 1);
    rd(9, 0, d); check("ti_count", d, 32'd10);
    cycle();
    rd(13, 0, d); check("ti_ip7", d[15], 1);
    mtc0(11, 0, 32'h0000_FFFF);
    check("ti_clear", timer_int, 0);

    mtc0(9, 0, 32'hFFFF_FFFF);
    cycle(); cycle();
    rd(9, 0, d); check("count_wrap", d, 32'h0);
    mtc0(3, 0, 32'hDEAD_BEEF);
    rd(3, 0, d); check("unmapped_read", d, 32'h0);

    // Same-cycle BadVAddr update alongside MTC0 EPC
    badvaddr_we = 1; badvaddr_in = 32'hCAFE_0004;
    mtc0(14, 0, 32'h0000_0200);
    badvaddr_we = 0;
    rd(8, 0, d); check("badvaddr", d, 32'hCAFE_0004);
    check("mtc0_epc", epc_out, 32'h0000_0200);

    for (int i = 0; i < 2500; i++) begin
      int pick;
      we = ($urandom_range(0, 99) < 35);
      pick = $urandom_range(0, 9);
      case (pick)
        0: begin waddr = 8;  wsel = 0; end
        1: begin waddr = 9;  wsel = 0; end
        2: begin waddr = 11; wsel = 0; end
        3: begin waddr = 12; wsel = 0; end
        4: begin waddr = 13; wsel = 0; end
        5: begin waddr = 14; wsel = 0; end
        6: begin waddr = 15; wsel = 3'($urandom_range(0, 1)); end
        7: begin waddr = 3;  wsel = 0; end
        default: begin waddr = 5'($urandom); wsel = 3'($urandom); end
      endcase
      wdata = $urandom;
      if (pick == 2 && $urandom_range(0, 1) == 1) wdata = m_count + $urandom_range(0, 6);
      exc_we = ($urandom_range(0, 99) < 8);
      exc_code = 5'($urandom); exc_epc = $urandom; exc_bd = 1'($urandom);
      clear_exl = ($urandom_range(0, 99) < 10);
      badvaddr_we = ($urandom_range(0, 99) < 10);
      badvaddr_in = $urandom;
      if (i % 8 == 0) hw_int = 6'($urandom);
      cycle();
      if (i == 1200) begin
        // Asynchronous reset arriving while an exception commit is pending
        idle(); exc_we = 1; exc_epc = 32'h1111_2222;
        #2 resetn = 0;
        #1;
        check("midrst_epc", epc_out, 0);
        check("midrst_exl", sr_exl, 0);
        check("midrst_bev", sr_bev, 1);
        check("midrst_timer", timer_int, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check("midrst_hold_epc", epc_out, 0);
        idle();
        resetn = 1;
        rd(12, 0, d); check("midrst_status", d, 32'h0040_0000);
      end
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
